// File: rtl/demux13_stream_pkg.sv
// Shared select encoding and default widths for the 1-to-3 stream demux
// and the matching 3:1 result-select mux.
package demux13_stream_pkg;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_C   = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    localparam int DEF_N  = 32;
    localparam int DEF_CW = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register. A load and a drain can happen
// in the same cycle.
module demux_slot
    import demux13_stream_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         out_ready,
    output logic         full,
    output logic         can_load,
    output logic         out_valid,
    output logic [N-1:0] out_data
);

    logic         full_q;
    logic [N-1:0] data_q;

    // A full slot can take a new beat only when its current beat leaves this cycle.
    assign can_load  = !full_q || out_ready;
    assign full      = full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (load) begin
            full_q <= 1'b1;
            data_q <= load_data;
        end else if (full_q && out_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/demux13_stream.sv
// 1-to-3 stream demultiplexer: steers each accepted beat to port a, b or c
// by in_sel; illegal selects are dropped, counted and flagged.
module demux13_stream
    import demux13_stream_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [1:0]    in_sel,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [N-1:0]  a_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [N-1:0]  b_data,
    output logic          c_valid,
    input  logic          c_ready,
    output logic [N-1:0]  c_data,
    output logic [CW-1:0] drop_cnt,
    output logic          err
);

    logic          can_a, can_b, can_c;
    logic          full_a, full_b, full_c;
    logic          accept;
    logic          load_a, load_b, load_c, drop;
    logic [CW-1:0] drop_cnt_q;
    logic          err_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // in_ready looks only at the selected slot, never at in_valid.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            SEL_A:   in_ready = can_a;
            SEL_B:   in_ready = can_b;
            SEL_C:   in_ready = can_c;
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign load_a = accept && (in_sel == SEL_A);
    assign load_b = accept && (in_sel == SEL_B);
    assign load_c = accept && (in_sel == SEL_C);
    assign drop   = accept && (in_sel == SEL_BAD);

    demux_slot #(.N(N)) u_slot_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .load_data(in_data),
        .out_ready(a_ready), .full(full_a), .can_load(can_a),
        .out_valid(a_valid), .out_data(a_data)
    );

    demux_slot #(.N(N)) u_slot_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .load_data(in_data),
        .out_ready(b_ready), .full(full_b), .can_load(can_b),
        .out_valid(b_valid), .out_data(b_data)
    );

    demux_slot #(.N(N)) u_slot_c (
        .clk(clk), .rst_n(rst_n), .load(load_c), .load_data(in_data),
        .out_ready(c_ready), .full(full_c), .can_load(can_c),
        .out_valid(c_valid), .out_data(c_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            err_q      <= 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err      = err_q;

    logic unused_full;
    assign unused_full = full_a ^ full_b ^ full_c;

endmodule

// File: tb/tb_demux13_stream.sv
// Directed bench for demux13_stream; a second instance with a 2-bit drop
// counter shares the stimulus so saturation is visible.
module tb_demux13_stream;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready, in_ready2;
    logic [N-1:0]  in_data;
    logic [1:0]    in_sel;
    logic          a_valid, b_valid, c_valid;
    logic          a_ready, b_ready, c_ready;
    logic [N-1:0]  a_data, b_data, c_data;
    logic [7:0]    drop_cnt;
    logic          err;
    logic          a_valid2, b_valid2, c_valid2;
    logic [N-1:0]  a_data2, b_data2, c_data2;
    logic [1:0]    drop_cnt2;
    logic          err2;

    int tests;
    int fails;

    demux13_stream #(.N(N), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .drop_cnt(drop_cnt), .err(err)
    );

    demux13_stream #(.N(N), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_sel(in_sel),
        .a_valid(a_valid2), .a_ready(a_ready), .a_data(a_data2),
        .b_valid(b_valid2), .b_ready(b_ready), .b_data(b_data2),
        .c_valid(c_valid2), .c_ready(c_ready), .c_data(c_data2),
        .drop_cnt(drop_cnt2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hDEAD_BEEF;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        #12;
        tests++;
        if ({a_valid, b_valid, c_valid} !== 3'b000) begin
            fails++; $display("FAIL reset_valid got=%b exp=000", {a_valid, b_valid, c_valid});
        end
        tests++;
        if ({a_data, b_data, c_data} !== '0) begin
            fails++; $display("FAIL reset_data got=%h %h %h exp=0", a_data, b_data, c_data);
        end
        tests++;
        if ({drop_cnt, err} !== 9'd0) begin
            fails++; $display("FAIL reset_cnt got=%0d err=%b exp=0/0", drop_cnt, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (b_valid !== 1'b1 || b_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL reset_first_b got=%b/%h exp=1/deadbeef", b_valid, b_data);
        end
        tests++;
        if (a_valid !== 1'b0 || c_valid !== 1'b0) begin
            fails++; $display("FAIL reset_other_ports got=%b%b exp=00", a_valid, c_valid);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if ({a_valid, b_valid, c_valid} !== 3'b000) begin
            fails++; $display("FAIL reset_drain got=%b exp=000", {a_valid, b_valid, c_valid});
        end
    endtask

    task automatic test_streaming();
        a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            in_data = i;
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL stream_ready beat=%0d got=%b exp=1", i, in_ready);
            end
            tick();
            tests++;
            if (a_valid !== 1'b1 || a_data !== 32'(i)) begin
                fails++; $display("FAIL stream_a beat=%0d got=%b/%h exp=1/%h", i, a_valid, a_data, i);
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (a_valid !== 1'b0) begin
            fails++; $display("FAIL stream_end got=%b exp=0", a_valid);
        end
    endtask

    task automatic test_back_pressure();
        c_ready = 1'b0;
        in_valid = 1'b1; in_sel = 2'b10; in_data = 32'h0000_00C1;
        tick();
        tests++;
        if (c_valid !== 1'b1 || c_data !== 32'h0000_00C1) begin
            fails++; $display("FAIL bp_c_first got=%b/%h exp=1/c1", c_valid, c_data);
        end
        in_data = 32'h0000_00C2;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_ready_blocked got=%b exp=0", in_ready);
        end
        tick();
        tests++;
        if (c_valid !== 1'b1 || c_data !== 32'h0000_00C1) begin
            fails++; $display("FAIL bp_c_held got=%b/%h exp=1/c1", c_valid, c_data);
        end
        in_sel = 2'b00; in_data = 32'h0000_00A5;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_a_ready got=%b exp=1", in_ready);
        end
        tick();
        tests++;
        if (a_valid !== 1'b1 || a_data !== 32'h0000_00A5 || c_data !== 32'h0000_00C1) begin
            fails++; $display("FAIL bp_a_side got=%b/%h c=%h exp=1/a5 c=c1", a_valid, a_data, c_data);
        end
        in_sel = 2'b10; in_data = 32'h0000_00C2;
        c_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_ready_release got=%b exp=1", in_ready);
        end
        tick();
        tests++;
        if (c_valid !== 1'b1 || c_data !== 32'h0000_00C2) begin
            fails++; $display("FAIL bp_c_second got=%b/%h exp=1/c2", c_valid, c_data);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (c_valid !== 1'b0 || a_valid !== 1'b0) begin
            fails++; $display("FAIL bp_drained got=c%b a%b exp=0 0", c_valid, a_valid);
        end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_sel = 2'b11; in_data = 32'h1234_5678;
        for (int i = 1; i <= 5; i++) begin
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL ill_ready beat=%0d got=%b exp=1", i, in_ready);
            end
            tick();
            tests++;
            if (err !== 1'b1 || drop_cnt !== 8'(i)) begin
                fails++; $display("FAIL ill_cnt beat=%0d got=%0d err=%b exp=%0d/1", i, drop_cnt, err, i);
            end
            tests++;
            if ({a_valid, b_valid, c_valid} !== 3'b000) begin
                fails++; $display("FAIL ill_no_out beat=%0d got=%b exp=000", i, {a_valid, b_valid, c_valid});
            end
            tests++;
            if (drop_cnt2 !== ((i < 3) ? 2'(i) : 2'd3)) begin
                fails++; $display("FAIL ill_sat beat=%0d got=%0d exp=%0d", i, drop_cnt2, (i < 3) ? i : 3);
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (err !== 1'b1 || drop_cnt !== 8'd5) begin
            fails++; $display("FAIL ill_sticky got=%0d err=%b exp=5/1", drop_cnt, err);
        end
    endtask

    task automatic test_simultaneous();
        b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h0000_00B1;
        tick();
        tests++;
        if (b_valid !== 1'b1 || b_data !== 32'h0000_00B1) begin
            fails++; $display("FAIL sim_b_first got=%b/%h exp=1/b1", b_valid, b_data);
        end
        b_ready = 1'b1; in_data = 32'h0000_00B2;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL sim_ready got=%b exp=1", in_ready);
        end
        tick();
        tests++;
        if (b_valid !== 1'b1 || b_data !== 32'h0000_00B2) begin
            fails++; $display("FAIL sim_refill got=%b/%h exp=1/b2", b_valid, b_data);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (b_valid !== 1'b0) begin
            fails++; $display("FAIL sim_drain got=%b exp=0", b_valid);
        end
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        in_valid = 1'b1;
        in_sel = 2'b00; in_data = 32'h0000_0011; tick();
        in_sel = 2'b01; in_data = 32'h0000_0022; tick();
        in_sel = 2'b10; in_data = 32'h0000_0033; tick();
        in_valid = 1'b0;
        tests++;
        if ({a_valid, b_valid, c_valid} !== 3'b111 || a_data !== 32'h11 || b_data !== 32'h22 || c_data !== 32'h33) begin
            fails++; $display("FAIL mid_full got=%b %h %h %h exp=111 11 22 33", {a_valid, b_valid, c_valid}, a_data, b_data, c_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({a_valid, b_valid, c_valid} !== 3'b000 || {a_data, b_data, c_data} !== '0) begin
            fails++; $display("FAIL mid_reset_slots got=%b %h %h %h exp=000 0 0 0", {a_valid, b_valid, c_valid}, a_data, b_data, c_data);
        end
        tests++;
        if (drop_cnt !== 8'd0 || err !== 1'b0 || drop_cnt2 !== 2'd0) begin
            fails++; $display("FAIL mid_reset_cnt got=%0d err=%b cnt2=%0d exp=0/0/0", drop_cnt, err, drop_cnt2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if ({a_valid, b_valid, c_valid} !== 3'b000) begin
            fails++; $display("FAIL mid_after got=%b exp=000", {a_valid, b_valid, c_valid});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_illegal();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
